// File: rtl/mul8_seq_ctrl_pkg.sv
// mul8_pkg: shared types and constants for the sequential 8x8 approximate
// multiplier (states, quadrant indices, shift amounts, map field positions,
// accumulator width and saturation value).
package mul8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Quadrants are visited in this order: HH, HL, LH, LL
  typedef logic [1:0] quad_t;
  localparam quad_t QUAD_HH = 2'd0;
  localparam quad_t QUAD_HL = 2'd1;
  localparam quad_t QUAD_LH = 2'd2;
  localparam quad_t QUAD_LL = 2'd3;

  localparam logic [3:0] SHIFT_HH = 4'd8;
  localparam logic [3:0] SHIFT_HL = 4'd4;
  localparam logic [3:0] SHIFT_LH = 4'd4;
  localparam logic [3:0] SHIFT_LL = 4'd0;

  // Bit position of each 2-bit cell-select field inside the map register
  localparam int MAP_POS_HH = 6;
  localparam int MAP_POS_HL = 4;
  localparam int MAP_POS_LH = 2;
  localparam int MAP_POS_LL = 0;

  localparam int          ACC_W             = 17;
  localparam logic [15:0] SAT_MAX           = 16'hFFFF;
  localparam logic [7:0]  MAP_RESET_DEFAULT = 8'b11_10_01_00;

  // Left shift applied to a quadrant's 4x4 product before accumulation
  function automatic logic [3:0] quadShift(input quad_t q);
    logic [3:0] s;
    case (q)
      QUAD_HH: s = SHIFT_HH;
      QUAD_HL: s = SHIFT_HL;
      QUAD_LH: s = SHIFT_LH;
      default: s = SHIFT_LL;
    endcase
    return s;
  endfunction

  // Cell-select code for a quadrant taken from a map value
  function automatic logic [1:0] mapField(input logic [7:0] m, input quad_t q);
    logic [1:0] f;
    case (q)
      QUAD_HH: f = m[MAP_POS_HH +: 2];
      QUAD_HL: f = m[MAP_POS_HL +: 2];
      QUAD_LH: f = m[MAP_POS_LH +: 2];
      default: f = m[MAP_POS_LL +: 2];
    endcase
    return f;
  endfunction

  // Lowest-index set bit of a pending-quadrant mask (HH is bit 0)
  function automatic quad_t firstPending(input logic [3:0] p);
    quad_t q;
    q = QUAD_HH;
    for (int i = 3; i >= 0; i--) begin
      if (p[i]) q = quad_t'(i);
    end
    return q;
  endfunction

endpackage

// File: rtl/mul8_seq_ctrl_if.sv
// Operand, product and configuration bundle of the sequential multiplier.
// master = operand producer / product consumer side, slave = the multiplier.
interface mul8_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        cfg_we;
  logic [7:0]  cfg_map;
  logic [7:0]  map_q;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_prod;
  logic        out_ovf;
  logic        busy;

  modport master (
    output in_valid, in_a, in_b, cfg_we, cfg_map, out_ready,
    input  in_ready, map_q, out_valid, out_prod, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, cfg_we, cfg_map, out_ready,
    output in_ready, map_q, out_valid, out_prod, out_ovf, busy
  );
endinterface

// File: rtl/mul8_seq_ctrl_mul4_sel.sv
// 4x4 approximate cells ap1..ap4 and the combinational selector mul4_sel
// that shares one pair of nibble inputs across all four cells.
//   ap1: exact product
//   ap2: exact product with the two LSBs dropped (under-estimates)
//   ap3: exact product with bit 1 forced high when a[1]&b[1] (over-estimates)
//   ap4: exact product plus 16 when a[3]&b[3] (over-estimates large products)
// Every cell returns 0 when either input is 0, and never exceeds 8 bits.

module ap1 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);
  assign p_o = {4'b0, a_i} * {4'b0, b_i};
endmodule

module ap2 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);
  logic [7:0] exact;
  assign exact = {4'b0, a_i} * {4'b0, b_i};
  assign p_o   = exact & 8'hFC;
endmodule

module ap3 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);
  logic [7:0] exact;
  assign exact = {4'b0, a_i} * {4'b0, b_i};
  assign p_o   = exact | {6'b0, a_i[1] & b_i[1], 1'b0};
endmodule

module ap4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);
  logic [7:0] exact;
  assign exact = {4'b0, a_i} * {4'b0, b_i};
  assign p_o   = exact + {3'b0, a_i[3] & b_i[3], 4'b0};
endmodule

module mul4_sel (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [1:0] sel_i,
  output logic [7:0] p_o
);
  logic [7:0] p1, p2, p3, p4;

  ap1 u_ap1 (.a_i(a_i), .b_i(b_i), .p_o(p1));
  ap2 u_ap2 (.a_i(a_i), .b_i(b_i), .p_o(p2));
  ap3 u_ap3 (.a_i(a_i), .b_i(b_i), .p_o(p3));
  ap4 u_ap4 (.a_i(a_i), .b_i(b_i), .p_o(p4));

  // Pick the product of the cell chosen for the current quadrant
  always_comb begin
    case (sel_i)
      2'd0:    p_o = p1;
      2'd1:    p_o = p2;
      2'd2:    p_o = p3;
      default: p_o = p4;
    endcase
  end
endmodule

// File: rtl/mul8_seq_ctrl.sv
// mul8_seq_ctrl: sequential 8x8 approximate multiplier. One 4x4 selectable
// core is time-shared over the HH, HL, LH, LL nibble quadrants; the shifted
// partial products are summed in a 17-bit accumulator and saturated to 16 bits.
// Optional feature: define MUL8_SKIP_ZERO_EN to skip quadrants whose a- or
// b-nibble is zero (latency becomes 1 + number of active quadrants).
module mul8_seq_ctrl
  import mul8_pkg::*;
#(
  parameter logic [7:0] RESET_MAP = MAP_RESET_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  mul8_seq_ctrl_if.slave  bus
);

  state_t           state_q, state_d;
  logic [7:0]       opA_q, opB_q, opMap_q, mapReg_q;
  logic [ACC_W-1:0] acc_q;
  quad_t            step_q;
  logic [3:0]       pend_q;
  logic [15:0]      prod_q;
  logic             ovf_q;

  logic [3:0]       aNib, bNib;
  logic [1:0]       cellSel;
  logic [7:0]       cellProd;
  logic [ACC_W-1:0] cellExt, accAdd, accSum;
  logic [3:0]       activeMask, pendNext;
  logic [15:0]      satProd;
  logic             satOvf;

  // Route the current quadrant's nibbles and cell code to the shared core
  always_comb begin
    aNib    = opA_q[3:0];
    bNib    = opB_q[3:0];
    cellSel = mapField(opMap_q, step_q);
    case (step_q)
      QUAD_HH: begin aNib = opA_q[7:4]; bNib = opB_q[7:4]; end
      QUAD_HL: begin aNib = opA_q[7:4]; bNib = opB_q[3:0]; end
      QUAD_LH: begin aNib = opA_q[3:0]; bNib = opB_q[7:4]; end
      default: begin aNib = opA_q[3:0]; bNib = opB_q[3:0]; end
    endcase
  end

  mul4_sel u_core (
    .a_i   (aNib),
    .b_i   (bNib),
    .sel_i (cellSel),
    .p_o   (cellProd)
  );

  // Shift, accumulate and saturate; the 17-bit sum cannot wrap
  always_comb begin
    cellExt  = {{(ACC_W-8){1'b0}}, cellProd};
    accAdd   = cellExt << quadShift(step_q);
    accSum   = acc_q + accAdd;
    satOvf   = accSum[ACC_W-1];
    satProd  = satOvf ? SAT_MAX : accSum[15:0];
    pendNext = pend_q & ~(4'b0001 << step_q);
  end

  // Quadrants that must be computed for the operands being offered
  always_comb begin
`ifdef MUL8_SKIP_ZERO_EN
    activeMask[QUAD_HH] = (|bus.in_a[7:4]) & (|bus.in_b[7:4]);
    activeMask[QUAD_HL] = (|bus.in_a[7:4]) & (|bus.in_b[3:0]);
    activeMask[QUAD_LH] = (|bus.in_a[3:0]) & (|bus.in_b[7:4]);
    activeMask[QUAD_LL] = (|bus.in_a[3:0]) & (|bus.in_b[3:0]);
`else
    activeMask = 4'hF;
`endif
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.in_valid) state_d = (activeMask == 4'h0) ? DONE : RUN;
      RUN:  if (pendNext == 4'h0) state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    bus.in_ready  = (state_q == IDLE) && !rst;
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q != IDLE);
    bus.out_prod  = prod_q;
    bus.out_ovf   = ovf_q;
    bus.map_q     = mapReg_q;
  end

  // Runtime map register, writable in any state
  always_ff @(posedge clk) begin
    if (rst)             mapReg_q <= RESET_MAP;
    else if (bus.cfg_we) mapReg_q <= bus.cfg_map;
  end

  // Operand capture, map snapshot, accumulation and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      opA_q   <= '0;
      opB_q   <= '0;
      opMap_q <= '0;
      acc_q   <= '0;
      step_q  <= QUAD_HH;
      pend_q  <= '0;
      prod_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            opA_q   <= bus.in_a;
            opB_q   <= bus.in_b;
            opMap_q <= mapReg_q;
            acc_q   <= '0;
            step_q  <= firstPending(activeMask);
            pend_q  <= activeMask;
            if (activeMask == 4'h0) begin
              prod_q <= '0;
              ovf_q  <= 1'b0;
            end
          end
        end
        RUN: begin
          acc_q  <= accSum;
          pend_q <= pendNext;
          if (pendNext != 4'h0) begin
            step_q <= firstPending(pendNext);
          end else begin
            prod_q <= satProd;
            ovf_q  <= satOvf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Directed testbench for mul8_seq_ctrl. Expected products are hand-computed
// from the ap1..ap4 cell definitions; random operands with an all-ap1 map are
// checked against the exact product. Define MUL8_SKIP_ZERO_EN for both builds.
module tb_mul8_seq_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   lat;

  mul8_seq_ctrl_if bus ();

  mul8_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a hung run
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: count it, and count and report it if it does not hold
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected latency from acceptance to out_valid for an operand pair
  function automatic int expLatency(input logic [7:0] a, input logic [7:0] b);
`ifdef MUL8_SKIP_ZERO_EN
    int cnt = 0;
    if (a[7:4] != 4'h0 && b[7:4] != 4'h0) cnt++;
    if (a[7:4] != 4'h0 && b[3:0] != 4'h0) cnt++;
    if (a[3:0] != 4'h0 && b[7:4] != 4'h0) cnt++;
    if (a[3:0] != 4'h0 && b[3:0] != 4'h0) cnt++;
    return (cnt == 0) ? 1 : 1 + cnt;
`else
    return 5;
`endif
  endfunction

  // Offer one operand pair, then wait (bounded) for out_valid; lat counts
  // the acceptance cycle as 1
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, output int latOut);
    int n;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    latOut = 1;
    while (!bus.out_valid && latOut < 40) begin
      @(posedge clk); #1;
      latOut++;
    end
  endtask

  // Consume the product and confirm the return to IDLE
  task automatic completeHandshake(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checkOutput({tag, "_validDrop"}, {31'b0, bus.out_valid}, 32'd0);
    checkOutput({tag, "_readyBack"}, {31'b0, bus.in_ready}, 32'd1);
  endtask

  task automatic writeMap(input logic [7:0] m);
    bus.cfg_we  = 1'b1;
    bus.cfg_map = m;
    @(posedge clk); #1;
    bus.cfg_we  = 1'b0;
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic [15:0] heldProd;
    int sawValid;
    total = 0;
    bad   = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = 8'h00;
    bus.in_b      = 8'h00;
    bus.cfg_we    = 1'b0;
    bus.cfg_map   = 8'h00;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_inReady", {31'b0, bus.in_ready}, 32'd0);
    checkOutput("rst_outValid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("rst_busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("rst_prod", {16'b0, bus.out_prod}, 32'h0);
    checkOutput("rst_ovf", {31'b0, bus.out_ovf}, 32'd0);
    checkOutput("rst_map", {24'b0, bus.map_q}, 32'hE4);
    rst = 1'b0;
    #1;
    checkOutput("idle_inReady", {31'b0, bus.in_ready}, 32'd1);

    // Zero multiplicand
    $display("[TB] zero operand");
    applyStimulus(8'h00, 8'h5A, lat);
    checkOutput("zero_lat", lat, expLatency(8'h00, 8'h5A));
    checkOutput("zero_prod", {16'b0, bus.out_prod}, 32'h0000);
    checkOutput("zero_ovf", {31'b0, bus.out_ovf}, 32'd0);
    completeHandshake("zero");
    checkOutput("zero_map", {24'b0, bus.map_q}, 32'hE4);

    // Reset map on 0x88*0x88: HH ap4=80, HL ap3=64, LH ap2=64, LL ap1=64
    $display("[TB] reset-map product and stall");
    applyStimulus(8'h88, 8'h88, lat);
    checkOutput("e4_lat", lat, 32'd5);
    checkOutput("e4_prod", {16'b0, bus.out_prod}, 32'h5840);
    checkOutput("e4_ovf", {31'b0, bus.out_ovf}, 32'd0);

    // Stall in DONE with a competing operand offered
    heldProd     = bus.out_prod;
    bus.in_a     = 8'h11;
    bus.in_b     = 8'h22;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("stall_prod", {16'b0, bus.out_prod}, 32'h5840);
      checkOutput("stall_ovf", {31'b0, bus.out_ovf}, 32'd0);
      checkOutput("stall_valid", {31'b0, bus.out_valid}, 32'd1);
      checkOutput("stall_inReady", {31'b0, bus.in_ready}, 32'd0);
    end
    bus.in_valid = 1'b0;
    completeHandshake("stall");
    @(posedge clk); #1;
    checkOutput("stall_idleBusy", {31'b0, bus.busy}, 32'd0);
    checkOutput("stall_heldProd", {16'b0, heldProd}, 32'h5840);

    // Map write at acceptance and during RUN: this op still uses 0xE4
    $display("[TB] map write at acceptance");
    bus.in_a     = 8'hFF;
    bus.in_b     = 8'hFF;
    bus.in_valid = 1'b1;
    bus.cfg_we   = 1'b1;
    bus.cfg_map  = 8'h1B;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
    checkOutput("cfg_mapNow", {24'b0, bus.map_q}, 32'h1B);
    @(posedge clk); #1;
    bus.cfg_we  = 1'b1;
    bus.cfg_map = 8'h1B;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    lat = 3;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("cfg_oldLat", lat, 32'd5);
    checkOutput("cfg_oldProd", {16'b0, bus.out_prod}, 32'hFFFF);
    checkOutput("cfg_oldOvf", {31'b0, bus.out_ovf}, 32'd1);
    completeHandshake("cfgOld");

    // Map 0x1B on 0xFF*0xFF: 225<<8 + 224<<4 + 227<<4 + 241 = 0xFE21
    applyStimulus(8'hFF, 8'hFF, lat);
    checkOutput("cfg_newProd", {16'b0, bus.out_prod}, 32'hFE21);
    checkOutput("cfg_newOvf", {31'b0, bus.out_ovf}, 32'd0);
    completeHandshake("cfgNew");
    // Map 0x1B on 0x88*0x88: 64<<8 + 64<<4 + 64<<4 + 80 = 0x4850
    applyStimulus(8'h88, 8'h88, lat);
    checkOutput("cfg_1bProd", {16'b0, bus.out_prod}, 32'h4850);
    completeHandshake("cfg1b");
    checkOutput("cfg_mapKept", {24'b0, bus.map_q}, 32'h1B);

    // All-ap1 map: the result is the exact product
    $display("[TB] exact map, random operands");
    writeMap(8'h00);
    checkOutput("map0", {24'b0, bus.map_q}, 32'h00);
    applyStimulus(8'h12, 8'h34, lat);
    checkOutput("exact_prod", {16'b0, bus.out_prod}, 32'h03A8);
    completeHandshake("exact");
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      applyStimulus(ra, rb, lat);
      checkOutput("rnd_lat", lat, expLatency(ra, rb));
      checkOutput("rnd_prod", {16'b0, bus.out_prod}, {16'b0, 16'({8'b0, ra} * {8'b0, rb})});
      checkOutput("rnd_ovf", {31'b0, bus.out_ovf}, 32'd0);
      completeHandshake("rnd");
    end

    // Reset during RUN step 2
    $display("[TB] reset mid-operation");
    bus.in_a     = 8'h12;
    bus.in_b     = 8'h34;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("mid_busy", {31'b0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("mid_outValid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("mid_busyAfter", {31'b0, bus.busy}, 32'd0);
    checkOutput("mid_inReadyRst", {31'b0, bus.in_ready}, 32'd0);
    checkOutput("mid_map", {24'b0, bus.map_q}, 32'hE4);
    rst = 1'b0;
    #1;
    checkOutput("mid_inReady", {31'b0, bus.in_ready}, 32'd1);
    sawValid = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) sawValid++;
    end
    checkOutput("mid_noOutput", sawValid, 32'd0);
    // Map 0xE4 on 0xFF*0xFF: 241<<8 + 227<<4 + 224<<4 + 225 = 69137 -> saturate
    applyStimulus(8'hFF, 8'hFF, lat);
    checkOutput("sat_lat", lat, 32'd5);
    checkOutput("sat_prod", {16'b0, bus.out_prod}, 32'hFFFF);
    checkOutput("sat_ovf", {31'b0, bus.out_ovf}, 32'd1);
    completeHandshake("sat");

    // Only LH active: ap2(F,F)=224, shifted by 4
    $display("[TB] single active quadrant");
    applyStimulus(8'h0F, 8'hF0, lat);
    checkOutput("lh_lat", lat, expLatency(8'h0F, 8'hF0));
    checkOutput("lh_prod", {16'b0, bus.out_prod}, 32'h0E00);
    checkOutput("lh_ovf", {31'b0, bus.out_ovf}, 32'd0);
    completeHandshake("lh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
